// File: rtl/svreal_arith_pipe.sv
// rtl/svreal_arith_pipe.sv - two-stage svreal fixed-point arithmetic unit with MAC accumulator
module svreal_arith_pipe #(
   parameter int WIDTH_A = 16,
   parameter int EXP_A   = -8,
   parameter int WIDTH_B = 17,
   parameter int EXP_B   = -9,
   parameter int WIDTH_O = 24,
   parameter int EXP_O   = -10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_A-1:0] a_i,
   input  logic [WIDTH_B-1:0] b_i,
   input  logic [2:0]         op_i,
   input  logic               acc_clr_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_O-1:0] res_o,
   output logic               sat_o,
   output logic [WIDTH_O-1:0] acc_o
);
   // Stage 1 keeps every op at one common exponent E1 (the finest of all op
   // exponents) so stage 2 needs a single lossless-until-floor conversion.
   localparam int EMIN  = (EXP_A < EXP_B) ? EXP_A : EXP_B;
   localparam int EXP_M = EXP_A + EXP_B;
   localparam int E1    = (EMIN < EXP_M) ? EMIN : EXP_M;
   localparam int SH_A  = EXP_A - E1;
   localparam int SH_B  = EXP_B - E1;
   localparam int SH_M  = EXP_M - E1;
   localparam int W_M   = WIDTH_A + WIDTH_B;
   localparam int W_AL  = ((WIDTH_A + SH_A) > (WIDTH_B + SH_B)) ? WIDTH_A + SH_A : WIDTH_B + SH_B;
   localparam int W_ADD = W_AL + 1;
   localparam int W_MUL = W_M + SH_M;
   localparam int W1    = (W_ADD > W_MUL) ? W_ADD : W_MUL;
   localparam int SHL   = (E1 > EXP_O) ? E1 - EXP_O : 0;
   localparam int SHR   = (EXP_O > E1) ? EXP_O - E1 : 0;
   localparam int WC0   = W1 + SHL;
   localparam int WC    = (WC0 > WIDTH_O) ? WC0 : WIDTH_O + 1;
   localparam logic [WIDTH_O-1:0] O_MAX = {1'b0, {(WIDTH_O-1){1'b1}}};
   localparam logic [WIDTH_O-1:0] O_MIN = {1'b1, {(WIDTH_O-1){1'b0}}};

   logic signed [W1-1:0]  a_e, b_e, m_e, s1_d;
   logic signed [W_M-1:0] prod;
   logic signed [W1-1:0]  s1_val_q;
   logic                  s1_valid_q, s1_mac_q, s1_clr_q;
   logic                  out_valid_q, sat_q;
   logic [WIDTH_O-1:0]    res_q, acc_q;

   logic signed [WC-1:0]  conv;
   logic                  conv_ok, sum_ok, sat_d;
   logic [WIDTH_O-1:0]    conv_sat, acc_base, sum_sat, res_d;
   logic [WIDTH_O:0]      sum;

   assign in_ready  = !(out_valid_q && !out_ready);
   assign out_valid = out_valid_q;
   assign res_o     = res_q;
   assign sat_o     = sat_q;
   assign acc_o     = acc_q;

   // Stage 1: full-precision result at exponent E1, wide enough never to overflow
   always_comb begin
      a_e  = W1'($signed(a_i)) <<< SH_A;
      b_e  = W1'($signed(b_i)) <<< SH_B;
      prod = W_M'($signed(a_i)) * W_M'($signed(b_i));
      m_e  = W1'(prod) <<< SH_M;
      s1_d = a_e + b_e;
      case (op_i)
         3'd0:    s1_d = a_e + b_e;
         3'd1:    s1_d = a_e - b_e;
         3'd2:    s1_d = m_e;
         3'd3:    s1_d = (a_e < b_e) ? a_e : b_e;
         3'd4:    s1_d = (a_e > b_e) ? a_e : b_e;
         3'd5:    s1_d = -a_e;
         3'd6:    s1_d = a_e[W1-1] ? -a_e : a_e;
         default: s1_d = m_e;
      endcase
   end

   // Stage 2: floor to EXP_O, saturate, and fold MAC beats into the accumulator
   always_comb begin
      conv     = (WC'(s1_val_q) <<< SHL) >>> SHR;
      conv_ok  = (&conv[WC-1:WIDTH_O-1]) | ~(|conv[WC-1:WIDTH_O-1]);
      conv_sat = conv_ok ? conv[WIDTH_O-1:0] : (conv[WC-1] ? O_MIN : O_MAX);
      acc_base = s1_clr_q ? '0 : acc_q;
      sum      = {acc_base[WIDTH_O-1], acc_base} + {conv_sat[WIDTH_O-1], conv_sat};
      sum_ok   = (sum[WIDTH_O] == sum[WIDTH_O-1]);
      sum_sat  = sum_ok ? sum[WIDTH_O-1:0] : (sum[WIDTH_O] ? O_MIN : O_MAX);
      res_d    = s1_mac_q ? sum_sat : conv_sat;
      sat_d    = !conv_ok || (s1_mac_q && !sum_ok);
   end

   // Whole pipeline advances together whenever the output register can take a beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_val_q    <= '0;
         s1_mac_q    <= 1'b0;
         s1_clr_q    <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         sat_q       <= 1'b0;
         acc_q       <= '0;
      end else if (in_ready) begin
         s1_valid_q  <= in_valid;
         if (in_valid) begin
            s1_val_q <= s1_d;
            s1_mac_q <= (op_i == 3'd7);
            s1_clr_q <= acc_clr_i;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q <= res_d;
            sat_q <= sat_d;
            if (s1_mac_q) begin
               acc_q <= sum_sat;
            end
         end
      end
   end
endmodule

// File: tb/tb_svreal_arith_pipe.sv
// tb/tb_svreal_arith_pipe.sv - directed self-checking bench for svreal_arith_pipe
module tb_svreal_arith_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_i;
   logic [16:0] b_i;
   logic [2:0]  op_i;
   logic        acc_clr_i;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] res_o;
   logic        sat_o;
   logic [23:0] acc_o;

   int n_vec = 0;
   int n_err = 0;

   svreal_arith_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_i       (a_i),
      .b_i       (b_i),
      .op_i      (op_i),
      .acc_clr_i (acc_clr_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_o     (res_o),
      .sat_o     (sat_o),
      .acc_o     (acc_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic chk(input string tag, input integer obs, input integer exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int a, input int b, input logic [2:0] op, input logic clr);
      in_valid  = 1'b1;
      a_i       = a[15:0];
      b_i       = b[16:0];
      op_i      = op;
      acc_clr_i = clr;
   endtask

   task automatic single(input string tag, input int a, input int b, input logic [2:0] op,
                         input integer exp_res, input integer exp_sat);
      @(negedge clk);
      drive(a, b, op, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_res"}, $signed(res_o), exp_res);
      chk({tag, "_sat"}, sat_o, exp_sat);
   endtask

   // Directed sequence
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a_i       = '0;
      b_i       = '0;
      op_i      = 3'd0;
      acc_clr_i = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_res", $signed(res_o), 0);
      chk("rst_sat", sat_o, 0);
      chk("rst_acc", $signed(acc_o), 0);
      rst = 1'b0;

      single("add",     384,   -128,  3'd0, 1280,     0);
      single("sub",     384,   -128,  3'd1, 1792,     0);
      single("mul_pos", 1,     1,     3'd2, 0,        0);
      single("mul_neg", 1,     -1,    3'd2, -1,       0);
      single("mul_max", 32767, 65535, 3'd2, 8388607,  1);
      single("mul_min", -32768, 65535, 3'd2, -8388608, 1);
      single("neg_min", -32768, 0,    3'd5, 131072,   0);
      single("abs_min", -32768, 0,    3'd6, 131072,   0);
      single("min",     256,   -512,  3'd3, -1024,    0);
      single("max",     256,   -512,  3'd4, 1024,     0);
      chk("acc_untouched", $signed(acc_o), 0);

      // MAC stream 1*1, 1*1, 1*-2, then an ADD that must leave acc alone
      @(negedge clk);
      drive(256, 512, 3'd7, 1'b1);
      @(negedge clk);
      drive(256, 512, 3'd7, 1'b0);
      @(negedge clk);
      chk("mac1_res", $signed(res_o), 1024);
      chk("mac1_acc", $signed(acc_o), 1024);
      drive(256, -1024, 3'd7, 1'b0);
      @(negedge clk);
      chk("mac2_res", $signed(res_o), 2048);
      chk("mac2_acc", $signed(acc_o), 2048);
      drive(384, -128, 3'd0, 1'b1);
      @(negedge clk);
      chk("mac3_res", $signed(res_o), 0);
      chk("mac3_acc", $signed(acc_o), 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mac_add_valid", out_valid, 1);
      chk("mac_add_res", $signed(res_o), 1280);
      chk("mac_add_acc", $signed(acc_o), 0);
      @(negedge clk);
      chk("mac_drain", out_valid, 0);

      // Backpressure: three beats offered while the consumer stalls
      out_ready = 1'b0;
      drive(256, 512, 3'd7, 1'b1);
      @(negedge clk);
      chk("bp_ready0", in_ready, 1);
      drive(384, -128, 3'd0, 1'b0);
      @(negedge clk);
      chk("bp_ready_drop", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_res_first", $signed(res_o), 1024);
      drive(256, 512, 3'd7, 1'b0);
      @(negedge clk);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_res", $signed(res_o), 1024);
      chk("bp_hold_acc", $signed(acc_o), 1024);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_second_res", $signed(res_o), 1280);
      chk("bp_second_acc", $signed(acc_o), 1024);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_third_res", $signed(res_o), 2048);
      chk("bp_third_acc", $signed(acc_o), 2048);
      @(negedge clk);
      chk("bp_drain", out_valid, 0);

      // Reset with two beats in flight and a non-zero accumulator
      drive(256, 512, 3'd7, 1'b0);
      @(negedge clk);
      drive(384, -128, 3'd0, 1'b0);
      @(negedge clk);
      chk("rst_mid_pre_valid", out_valid, 1);
      chk("rst_mid_pre_acc", $signed(acc_o), 3072);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_res", $signed(res_o), 0);
      chk("rst_mid_acc", $signed(acc_o), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_stale", out_valid, 0);
      end
      chk("rst_end_acc", $signed(acc_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/svreal_arith_pipe.md
Name: svreal_arith_pipe

Overview:
- Pipelined, parametrised fixed-point arithmetic unit for the svreal fixed-point representation: real value = signed integer × 2^EXP.
- Operands A and B each have their own width and exponent. Every result is aligned, floored and saturated into one output format.
- Provides a runtime-selectable operation, a valid/ready handshake with backpressure, a saturation flag and a multiply-accumulate mode with an internal accumulator.
- Sits between svreal producers and consumers where a registered, throughput-1 datapath is required instead of combinational macros.

Parameters:
- WIDTH_A, 16, bit width of operand A (signed).
- EXP_A, -8, exponent of operand A.
- WIDTH_B, 17, bit width of operand B (signed).
- EXP_B, -9, exponent of operand B.
- WIDTH_O, 24, bit width of result and accumulator (signed).
- EXP_O, -10, exponent of result and accumulator.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a_i  in  WIDTH_A  operand A, signed integer mantissa.
- b_i  in  WIDTH_B  operand B, signed integer mantissa.
- op_i  in  3  operation: 0 ADD, 1 SUB, 2 MUL, 3 MIN, 4 MAX, 5 NEG(a), 6 ABS(a), 7 MAC.
- acc_clr_i  in  1  with a MAC beat, the accumulator is treated as 0 before adding.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res_o  out  WIDTH_O  result mantissa, exponent EXP_O.
- sat_o  out  1  result was clipped to the output range.
- acc_o  out  WIDTH_O  current accumulator value.

Behaviour:
- Reset (async, rst=1): both stage valids, out_valid, res_o, sat_o, acc_o and the accumulator go to 0. Any in-flight beats are discarded; no output is produced for them after reset release.
- Transfer rule: an input beat is accepted when in_valid && in_ready. An output beat completes when out_valid && out_ready.
- in_ready = !(out_valid && !out_ready). The whole pipeline advances only when in_ready is 1; it has no bubbles under stall and no skid buffer.
- Latency: exactly 2 accepted-clock advances from input acceptance to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Stage 1 registers a full-precision result with no loss.
  - ADD/SUB/MIN/MAX: both operands are aligned to exponent min(EXP_A,EXP_B) by left shift. The result has a width large enough to never overflow.
  - MUL: full product of width WIDTH_A+WIDTH_B at exponent EXP_A+EXP_B.
  - NEG/ABS: operate on A only at EXP_A, widened by 1 bit, so that NEG/ABS of the most negative value is exact.
  - MAC: same as MUL.
- Stage 2 converts the full-precision value to EXP_O.
  - If the exponent is larger than EXP_O, shift left. If it is smaller, apply an arithmetic right shift, which floors toward -inf.
  - Then saturate to [-2^(WIDTH_O-1), 2^(WIDTH_O-1)-1]. sat_o=1 if clipping occurred.
  - The result registers into res_o and sat_o.
- MAC in stage 2:
  - Compute sum = (acc_clr ? 0 : acc) + converted product, at full precision, then saturate.
  - res_o, acc and acc_o take the sum. sat_o is set if either the product conversion or the sum clipped.
  - acc updates only when the MAC beat advances into the output register.
- Non-MAC ops never modify acc. acc_clr_i is ignored on non-MAC beats.
- Back-to-back MAC beats: each beat uses the acc produced by the previous MAC beat, with no hazard bubble. The accumulate is in the same stage as the acc register.
- Stall: while in_ready=0, every stage register, res_o, sat_o and acc hold their value, and out_valid stays 1.
- res_o and sat_o hold the last value when out_valid=0.

Test Plan:
- ADD: a_i=384 (1.5), b_i=-128 (-0.25), op=0 -> after 2 cycles out_valid=1, res_o=1280 (1.25), sat_o=0.
- MUL flooring: a_i=1, b_i=1 (product 2^-17) -> res_o=0. a_i=1, b_i=-1 -> res_o=-1.
- Saturation: a_i=32767, b_i=65535, op=2 -> res_o=8388607, sat_o=1. NEG of a_i=-32768 -> res_o=131072, sat_o=0.
- MAC stream: beats (a=256, b=512, clr=1), (256, 512, 0), (256, -1024, 0), i.e. 1×1, 1×1, 1×-2 -> res_o sequence 1024, 2048, 0. acc_o ends at 0. An interleaved ADD beat leaves acc unchanged.
- Backpressure: hold out_ready=0 with 3 beats offered -> in_ready drops once out_valid=1. After release, results emerge in order with no loss or duplicates, and acc follows the MAC order.
- Reset mid-operation: assert rst with 2 beats in flight and acc≠0 -> out_valid, acc_o and res_o go to 0 immediately. No stale output appears after release.
